// File: rtl/uart_pkg.sv
// Shared definitions for the UART: register map, configuration layout,
// FSM state encodings and the parity helper.
package uart_pkg;

  localparam logic [3:0] ADDR_DIV_LO = 4'h0;
  localparam logic [3:0] ADDR_DIV_HI = 4'h1;
  localparam logic [3:0] ADDR_CONFIG = 4'h7;

  typedef struct packed {
    logic loopback;
    logic two_stop;
    logic nine_bits;
    logic odd_par;
    logic par_en;
  } config_t;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // Parity bit that makes the total count of ones even (or odd when odd=1).
  function automatic logic parity_bit(input logic [8:0] word, input logic nine, input logic odd);
    parity_bit = (nine ? ^word : ^word[7:0]) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, parity/stop checks.
// Frame settings are captured at the start edge so a frame completes with its own config.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_par_en,
  input  logic             i_odd_par,
  input  logic             i_nine_bits,
  output logic [8:0]       o_word,
  output logic             o_good,
  output logic             o_bad
);
  // state     | meaning
  // RX_IDLE   | waiting for a falling edge on the synchronised line
  // RX_START  | half-bit wait, then re-check start bit (glitch filter)
  // RX_DATA   | sampling data bits at bit centre
  // RX_PARITY | sampling parity bit
  // RX_STOP   | sampling first stop bit, flag good/bad, back to idle

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  rx_state_t        state, state_nx;
  logic             rx_meta, rx_sync, rx_prev;
  logic [DIV_W-1:0] cnt, cnt_nx, div, div_nx;
  logic [3:0]       bit_idx, bit_idx_nx;
  logic [8:0]       word, word_nx;
  logic             par_en, par_en_nx, odd_par, odd_par_nx, nine, nine_nx;
  logic             par_err, par_err_nx;
  logic             tc, last_bit;

  assign tc       = (cnt == '0);
  assign last_bit = (bit_idx == (nine ? 4'd8 : 4'd7));
  assign o_word   = word;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      div     <= '0;
      bit_idx <= '0;
      word    <= '0;
      par_en  <= 1'b0;
      odd_par <= 1'b0;
      nine    <= 1'b0;
      par_err <= 1'b0;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state   <= state_nx;
      cnt     <= cnt_nx;
      div     <= div_nx;
      bit_idx <= bit_idx_nx;
      word    <= word_nx;
      par_en  <= par_en_nx;
      odd_par <= odd_par_nx;
      nine    <= nine_nx;
      par_err <= par_err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = tc ? cnt : cnt - ONE;
    div_nx     = div;
    bit_idx_nx = bit_idx;
    word_nx    = word;
    par_en_nx  = par_en;
    odd_par_nx = odd_par;
    nine_nx    = nine;
    par_err_nx = par_err;
    o_good     = 1'b0;
    o_bad      = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nx = cnt;
        if (rx_prev && !rx_sync) begin
          state_nx   = RX_START;
          cnt_nx     = (i_div >> 1) - ONE;
          div_nx     = i_div;
          par_en_nx  = i_par_en;
          odd_par_nx = i_odd_par;
          nine_nx    = i_nine_bits;
          word_nx    = '0;
          par_err_nx = 1'b0;
        end
      end
      RX_START: if (tc) begin
        if (rx_sync) begin
          state_nx = RX_IDLE;
        end else begin
          state_nx   = RX_DATA;
          cnt_nx     = div - ONE;
          bit_idx_nx = '0;
        end
      end
      RX_DATA: if (tc) begin
        word_nx[bit_idx] = rx_sync;
        cnt_nx           = div - ONE;
        bit_idx_nx       = bit_idx + 4'd1;
        if (last_bit) state_nx = par_en ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (tc) begin
        par_err_nx = (rx_sync != parity_bit(word, nine, odd_par));
        cnt_nx     = div - ONE;
        state_nx   = RX_STOP;
      end
      RX_STOP: if (tc) begin
        state_nx = RX_IDLE;
        if (!rx_sync || par_err) o_bad = 1'b1;
        else                     o_good = 1'b1;
      end
      default: state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_top.sv
// Full-duplex UART top: register file, bus read mux, TX FSM and RX instance.
// Optional internal loopback (CONFIG[4]) is built only when UART_LOOPBACK_EN is defined.
module uart_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DIV_W        = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_request_tx,
  input  logic       i_ws_n,
  input  logic       i_rs_n,
  input  logic [3:0] i_addr,
  input  logic [8:0] i_data,
  output logic [8:0] o_data,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_ready,
  output logic       o_rx_error,
  output logic       o_rx_valid
);
  // state     | meaning
  // TX_IDLE   | line idle high, o_ready=1, waiting for request
  // TX_START  | driving start bit
  // TX_DATA   | driving data bits LSB first
  // TX_PARITY | driving parity bit (only when enabled)
  // TX_STOP   | driving one or two stop bits

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);

  logic [DIV_W-1:0] div_reg, div_eff;
  config_t          cfg_reg, cfg_wr;
  logic [8:0]       rd_data, rx_word;
  logic             rx_good, rx_bad, rx_line;

  tx_state_t        tx_state, tx_state_nx;
  logic [DIV_W-1:0] tx_cnt, tx_cnt_nx, tx_div, tx_div_nx;
  logic [3:0]       tx_bit, tx_bit_nx;
  logic [8:0]       tx_word, tx_word_nx;
  logic             tx_par_en, tx_par_en_nx, tx_odd, tx_odd_nx;
  logic             tx_nine, tx_nine_nx, tx_two_stop, tx_two_stop_nx;
  logic             tx_line, tx_line_nx, tx_tc;

  // Clamp on use so byte-wise divisor writes never pass through an illegal value.
  assign div_eff = (div_reg < DIV_MIN) ? DIV_MIN : div_reg;
  assign o_tx    = tx_line;
  assign o_ready = (tx_state == TX_IDLE);
  assign tx_tc   = (tx_cnt == '0);

  always_comb begin
    cfg_wr = config_t'(i_data[4:0]);
`ifndef UART_LOOPBACK_EN
    cfg_wr.loopback = 1'b0;
`endif
  end

`ifdef UART_LOOPBACK_EN
  assign rx_line = cfg_reg.loopback ? tx_line : i_rx;
`else
  assign rx_line = i_rx;
`endif

  always_comb begin
    rd_data = '0;
    case (i_addr)
      ADDR_DIV_LO: rd_data = {1'b0, div_reg[7:0]};
      ADDR_DIV_HI: rd_data = 9'(div_reg[DIV_W-1:8]);
      ADDR_CONFIG: rd_data = 9'(cfg_reg);
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_reg <= DIV_W'(CLKS_PER_BIT);
      cfg_reg <= '0;
    end else if (!i_ws_n) begin
      case (i_addr)
        ADDR_DIV_LO: div_reg[7:0]       <= i_data[7:0];
        ADDR_DIV_HI: div_reg[DIV_W-1:8] <= i_data[DIV_W-9:0];
        ADDR_CONFIG: cfg_reg            <= cfg_wr;
        default: ;
      endcase
    end
  end

  // A received word takes priority over a same-cycle register read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data     <= '0;
      o_rx_valid <= 1'b0;
      o_rx_error <= 1'b0;
    end else begin
      o_rx_valid <= rx_good;
      o_rx_error <= rx_bad;
      if (rx_good)     o_data <= rx_word;
      else if (!i_rs_n) o_data <= rd_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_div      <= '0;
      tx_bit      <= '0;
      tx_word     <= '0;
      tx_par_en   <= 1'b0;
      tx_odd      <= 1'b0;
      tx_nine     <= 1'b0;
      tx_two_stop <= 1'b0;
      tx_line     <= 1'b1;
    end else begin
      tx_state    <= tx_state_nx;
      tx_cnt      <= tx_cnt_nx;
      tx_div      <= tx_div_nx;
      tx_bit      <= tx_bit_nx;
      tx_word     <= tx_word_nx;
      tx_par_en   <= tx_par_en_nx;
      tx_odd      <= tx_odd_nx;
      tx_nine     <= tx_nine_nx;
      tx_two_stop <= tx_two_stop_nx;
      tx_line     <= tx_line_nx;
    end
  end

  always_comb begin
    tx_state_nx    = tx_state;
    tx_cnt_nx      = tx_tc ? tx_cnt : tx_cnt - ONE;
    tx_div_nx      = tx_div;
    tx_bit_nx      = tx_bit;
    tx_word_nx     = tx_word;
    tx_par_en_nx   = tx_par_en;
    tx_odd_nx      = tx_odd;
    tx_nine_nx     = tx_nine;
    tx_two_stop_nx = tx_two_stop;
    tx_line_nx     = tx_line;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nx  = tx_cnt;
        tx_line_nx = 1'b1;
        if (i_request_tx) begin
          tx_state_nx    = TX_START;
          tx_cnt_nx      = div_eff - ONE;
          tx_div_nx      = div_eff;
          tx_word_nx     = cfg_reg.nine_bits ? i_data : {1'b0, i_data[7:0]};
          tx_par_en_nx   = cfg_reg.par_en;
          tx_odd_nx      = cfg_reg.odd_par;
          tx_nine_nx     = cfg_reg.nine_bits;
          tx_two_stop_nx = cfg_reg.two_stop;
          tx_line_nx     = 1'b0;
        end
      end
      TX_START: if (tx_tc) begin
        tx_state_nx = TX_DATA;
        tx_cnt_nx   = tx_div - ONE;
        tx_bit_nx   = '0;
        tx_line_nx  = tx_word[0];
      end
      TX_DATA: if (tx_tc) begin
        tx_cnt_nx = tx_div - ONE;
        if (tx_bit == (tx_nine ? 4'd8 : 4'd7)) begin
          if (tx_par_en) begin
            tx_state_nx = TX_PARITY;
            tx_line_nx  = parity_bit(tx_word, tx_nine, tx_odd);
          end else begin
            tx_state_nx = TX_STOP;
            tx_bit_nx   = '0;
            tx_line_nx  = 1'b1;
          end
        end else begin
          tx_bit_nx  = tx_bit + 4'd1;
          tx_line_nx = tx_word[tx_bit + 4'd1];
        end
      end
      TX_PARITY: if (tx_tc) begin
        tx_state_nx = TX_STOP;
        tx_cnt_nx   = tx_div - ONE;
        tx_bit_nx   = '0;
        tx_line_nx  = 1'b1;
      end
      TX_STOP: if (tx_tc) begin
        if (tx_two_stop && tx_bit == 4'd0) begin
          tx_bit_nx = 4'd1;
          tx_cnt_nx = tx_div - ONE;
        end else begin
          tx_state_nx = TX_IDLE;
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  uart_rx #(.DIV_W(DIV_W)) u_rx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (rx_line),
    .i_div       (div_eff),
    .i_par_en    (cfg_reg.par_en),
    .i_odd_par   (cfg_reg.odd_par),
    .i_nine_bits (cfg_reg.nine_bits),
    .o_word      (rx_word),
    .o_good      (rx_good),
    .o_bad       (rx_bad)
  );

endmodule

// File: tb/tb_uart_top.sv
// Scoreboard bench for uart_top: expected RX results are queued at stimulus time
// and a negedge monitor pops/compares on every o_rx_valid / o_rx_error pulse.
module tb_uart_top;
  import uart_pkg::*;

  logic       i_clk, i_rst, i_request_tx, i_ws_n, i_rs_n, i_rx;
  logic       o_tx, o_ready, o_rx_error, o_rx_valid;
  logic [3:0] i_addr;
  logic [8:0] i_data, o_data;
  logic       loop_en, rx_drv;
  int         vectors = 0;
  int         miscompares = 0;
  int         cur_div = 868;

  typedef struct packed {
    logic       is_err;
    logic [8:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [8:0] bytes [5] = '{9'h0A5, 9'h000, 9'h0FF, 9'h05A, 9'h081};

  assign i_rx = loop_en ? o_tx : rx_drv;

  uart_top #(.CLKS_PER_BIT(868), .DIV_W(16)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_request_tx (i_request_tx),
    .i_ws_n       (i_ws_n),
    .i_rs_n       (i_rs_n),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .o_data       (o_data),
    .i_rx         (i_rx),
    .o_tx         (o_tx),
    .o_ready      (o_ready),
    .o_rx_error   (o_rx_error),
    .o_rx_valid   (o_rx_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic exp_t mk(input logic e, input logic [8:0] d);
    mk = {e, d};
  endfunction

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [8:0] d);
    i_ws_n = 1'b0; i_addr = a; i_data = d;
    @(negedge i_clk);
    i_ws_n = 1'b1;
  endtask

  task automatic reg_read_check(input string name, input logic [3:0] a, input logic [8:0] want);
    i_rs_n = 1'b0; i_addr = a;
    @(negedge i_clk);
    i_rs_n = 1'b1;
    check(name, int'(o_data), int'(want));
  endtask

  task automatic send(input logic [8:0] w, output int low);
    int g;
    g = 0;
    while (o_ready !== 1'b1 && g < 20000) begin @(negedge i_clk); g++; end
    if (g >= 20000) begin
      vectors++; miscompares++;
      $display("FAIL send_wait_ready timeout got o_ready=%0b want 1", o_ready);
    end
    i_data = w; i_request_tx = 1'b1;
    @(negedge i_clk);
    i_request_tx = 1'b0;
    low = 0;
    while (o_ready !== 1'b1 && low < 20000) begin @(negedge i_clk); low++; end
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin @(negedge i_clk); g++; end
    if (exp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL %s timeout got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_drv = b;
    repeat (cur_div) @(negedge i_clk);
  endtask

  task automatic drive_frame(input logic [8:0] w, input int nbits, input logic has_par,
                             input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(w[i]);
    if (has_par) drive_bit(par);
    drive_bit(stop);
    rx_drv = 1'b1;
    repeat (2 * cur_div) @(negedge i_clk);
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && (o_rx_valid || o_rx_error)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rx_unexpected got valid=%0b error=%0b data=0x%03h want no pulse",
                 o_rx_valid, o_rx_error, o_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_rx_valid == mon_e.is_err || o_rx_error != mon_e.is_err || o_data != mon_e.data) begin
          miscompares++;
          $display("FAIL rx_frame got valid=%0b error=%0b data=0x%03h want error=%0b data=0x%03h",
                   o_rx_valid, o_rx_error, o_data, mon_e.is_err, mon_e.data);
        end
      end
    end
  end

  initial begin
    int low, bad;
    i_rst = 1'b1; i_request_tx = 1'b0; i_ws_n = 1'b1; i_rs_n = 1'b1;
    i_addr = '0; i_data = '0; loop_en = 1'b1; rx_drv = 1'b1;
    repeat (25) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_o_data", int'(o_data), 0);
    check("rst_o_tx", int'(o_tx), 1);
    check("rst_o_ready", int'(o_ready), 1);
    check("rst_o_rx_error", int'(o_rx_error), 0);
    check("rst_o_rx_valid", int'(o_rx_valid), 0);
    reg_read_check("rd_div_lo_default", ADDR_DIV_LO, 9'h064);
    reg_read_check("rd_div_hi_default", ADDR_DIV_HI, 9'h003);

    // default 8N1 loopback at 868 cycles/bit
    foreach (bytes[k]) begin
      exp_q.push_back(mk(1'b0, bytes[k]));
      send(bytes[k], low);
      check("len_8n1", low, 10 * 868);
      drain("drain_8n1");
    end

    // even parity, two stop bits
    reg_write(ADDR_CONFIG, 9'h009);
    exp_q.push_back(mk(1'b0, 9'h03C));
    send(9'h03C, low);
    check("len_8e2", low, 12 * 868);
    drain("drain_8e2");

    // nine data bits at DIV=16
    reg_write(ADDR_DIV_LO, 9'h010);
    reg_write(ADDR_DIV_HI, 9'h000);
    reg_write(ADDR_CONFIG, 9'h004);
    cur_div = 16;
    reg_read_check("rd_div_lo", ADDR_DIV_LO, 9'h010);
    reg_read_check("rd_div_hi", ADDR_DIV_HI, 9'h000);
    reg_read_check("rd_unmapped", 4'h3, 9'h000);
    exp_q.push_back(mk(1'b0, 9'h1A5));
    send(9'h1A5, low);
    check("len_9n1", low, 11 * 16);
    drain("drain_9n1");
    reg_read_check("rd_config", ADDR_CONFIG, 9'h004);

    // external frames: bad stop bit, glitch, parity error, good parity frame
    loop_en = 1'b0;
    exp_q.push_back(mk(1'b1, 9'h004));
    drive_frame(9'h0F3, 9, 1'b0, 1'b0, 1'b0);
    drain("drain_stop_err");
    rx_drv = 1'b0;
    repeat (3) @(negedge i_clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge i_clk);
    check("glitch_hold", int'(o_data), 9'h004);
    reg_write(ADDR_CONFIG, 9'h001);
    exp_q.push_back(mk(1'b1, 9'h004));
    drive_frame(9'h001, 8, 1'b1, 1'b0, 1'b1);
    drain("drain_par_err");
    exp_q.push_back(mk(1'b0, 9'h001));
    drive_frame(9'h001, 8, 1'b1, 1'b1, 1'b1);
    drain("drain_par_ok");

    // request while busy is ignored
    reg_write(ADDR_CONFIG, 9'h000);
    loop_en = 1'b1;
    @(negedge i_clk);
    exp_q.push_back(mk(1'b0, 9'h055));
    i_data = 9'h055; i_request_tx = 1'b1;
    @(negedge i_clk);
    i_request_tx = 1'b0;
    repeat (20) @(negedge i_clk);
    check("busy_ready_low", int'(o_ready), 0);
    i_data = 9'h099; i_request_tx = 1'b1;
    @(negedge i_clk);
    i_request_tx = 1'b0;
    bad = 0;
    while (o_ready !== 1'b1 && bad < 2000) begin @(negedge i_clk); bad++; end
    check("busy_frame_done", int'(o_ready), 1);
    drain("drain_busy");
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1 || o_ready !== 1'b1) bad++;
    end
    check("no_second_frame", bad, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
